// File: rtl/exponential.sv
// Iterative fixed-point e^x evaluator for x in [0,1): 8-term Taylor series,
// start/done handshake, result in 2.16 format.
module exponential (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        done,
    output logic [1:0]  intpart,
    output logic [15:0] fracpart
);

    localparam int unsigned NTERMS = 8;
    localparam int unsigned XW     = 16;
    localparam int unsigned TW     = 18;
    localparam int unsigned KW     = 4;
    localparam int unsigned RW     = 17;
    localparam int unsigned MPW    = TW + XW;
    localparam int unsigned DPW    = TW + RW;

    localparam logic [TW-1:0] ONE       = 18'h10000;
    localparam logic [KW-1:0] K_LAST    = KW'(NTERMS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REL,
        LOAD,
        MUL,
        DIV,
        ACC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   xr_q, xr_d;
    logic [TW-1:0]   term_q, term_d;
    logic [TW-1:0]   sum_q, sum_d;
    logic [KW-1:0]   k_q, k_d;
    logic            done_q, done_d;
    logic [1:0]      intpart_q, intpart_d;
    logic [15:0]     fracpart_q, fracpart_d;

    logic [RW-1:0]   recip_c;
    logic [MPW-1:0]  mul_prod_c;
    logic [DPW-1:0]  div_prod_c;
    logic [TW-1:0]   acc_c;

    // Reciprocal ROM: floor(65536/k) for k = 1..8
    always_comb begin
        recip_c = '0;
        case (k_q)
            4'd1:    recip_c = 17'd65536;
            4'd2:    recip_c = 17'd32768;
            4'd3:    recip_c = 17'd21845;
            4'd4:    recip_c = 17'd16384;
            4'd5:    recip_c = 17'd13107;
            4'd6:    recip_c = 17'd10922;
            4'd7:    recip_c = 17'd9362;
            4'd8:    recip_c = 17'd8192;
            default: recip_c = '0;
        endcase
    end

    // Shared datapath: full-width unsigned products, truncated on use
    always_comb begin
        mul_prod_c = MPW'(term_q) * MPW'(xr_q);
        div_prod_c = DPW'(term_q) * DPW'(recip_c);
        acc_c      = sum_q + term_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        xr_d       = xr_q;
        term_d     = term_q;
        sum_d      = sum_q;
        k_d        = k_q;
        done_d     = 1'b0;
        intpart_d  = intpart_q;
        fracpart_d = fracpart_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                xr_d    = x;
                term_d  = ONE;
                sum_d   = ONE;
                k_d     = KW'(1);
                state_d = MUL;
            end
            MUL: begin
                term_d  = TW'(mul_prod_c >> XW);
                state_d = DIV;
            end
            DIV: begin
                term_d  = TW'(div_prod_c >> 16);
                state_d = ACC;
            end
            ACC: begin
                sum_d = acc_c;
                if (k_q == K_LAST) begin
                    // Publish the result together with the done pulse
                    done_d     = 1'b1;
                    intpart_d  = acc_c[17:16];
                    fracpart_d = acc_c[15:0];
                    state_d    = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            xr_q       <= '0;
            term_q     <= '0;
            sum_q      <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            intpart_q  <= '0;
            fracpart_q <= '0;
        end else begin
            state_q    <= state_d;
            xr_q       <= xr_d;
            term_q     <= term_d;
            sum_q      <= sum_d;
            k_q        <= k_d;
            done_q     <= done_d;
            intpart_q  <= intpart_d;
            fracpart_q <= fracpart_d;
        end
    end

    assign done     = done_q;
    assign intpart  = intpart_q;
    assign fracpart = fracpart_q;

endmodule

// File: tb/tb_exponential.sv
// Scoreboard bench for the exponential co-processor.
module tb_exponential;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic        done;
    logic [1:0]  intpart;
    logic [15:0] fracpart;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [17:0] exp_top;
        int          tol;
        int          e0;
    } sb_entry_t;

    sb_entry_t sb[$];

    exponential dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .done     (done),
        .intpart  (intpart),
        .fracpart (fracpart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passes when got is at most exp and no more than tol below it
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp, input int tol = 0);
        checks++;
        if (got > exp || (exp - got) > 32'(tol)) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (tol %0d below)", tag, got, exp, tol);
        end
    endtask

    // Compare each completion against the oldest outstanding request
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check_val("latency", 32'(cyc - e.e0), 32'd25);
                check_val("result", {14'b0, intpart, fracpart}, {14'b0, e.exp_top}, e.tol);
            end
        end
    end

    // Hold start high two cycles, release, and record the release edge
    task automatic launch(input logic [15:0] xv, input logic [17:0] exp_top, input int tol);
        sb_entry_t e;
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start     = 1'b0;
        e.exp_top = exp_top;
        e.tol     = tol;
        e.e0      = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        x     = 16'h0000;

        // Reset held with start toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
            #1;
            check_val("rst_done", 32'(done), 32'd0);
            check_val("rst_int", 32'(intpart), 32'd0);
            check_val("rst_frac", 32'(fracpart), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_result", {14'b0, intpart, fracpart}, 32'd0);

        // Basic points
        launch(16'h8000, {2'd1, 16'hA613}, 24);
        wait_done();
        launch(16'h0000, 18'h10000, 0);
        wait_done();
        launch(16'hFFFF, {2'd2, 16'hB7DF}, 24);
        wait_done();

        // start and x disturbed while busy
        launch(16'h4000, {2'd1, 16'h48B6}, 24);
        repeat (5) @(negedge clk);
        start = 1'b1;
        x     = 16'hFFFF;
        repeat (5) @(negedge clk);
        x = 16'h1234;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();

        // Back-to-back requests
        launch(16'h8000, {2'd1, 16'hA613}, 24);
        wait_done();
        launch(16'hFFFF, {2'd2, 16'hB7DF}, 24);
        wait_done();

        // Reset mid-operation: immediate clear, no done pulse
        launch(16'h0000, 18'h10000, 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_int", 32'(intpart), 32'd0);
        check_val("midrst_frac", 32'(fracpart), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_val("post_rst_result", {14'b0, intpart, fracpart}, 32'd0);

        launch(16'h4000, {2'd1, 16'h48B6}, 24);
        wait_done();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
